// File: rtl/mem_bus_arbiter.sv
// Shares one single-port SRAM-like bus between instruction fetch (IF) and data access (MEM).
// One transaction at a time, sequenced IDLE -> ADDR -> DATA, with a per-phase watchdog.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    output logic        inst_stall,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_excp,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    output logic        data_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Count value seen in the last allowed cycle of a phase.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic inst_elig;
    logic data_elig;
    logic wd_hit;
    logic grant_data;
    logic grant_inst;
    logic excp_done;
    logic done;
    logic expired;
    logic finish;

    // A requester sitting in its own ok cycle is not re-granted.
    assign inst_elig = inst_req & ~inst_ok;
    assign data_elig = data_req & ~data_ok;
    assign wd_hit    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign finish    = done | expired;

    assign inst_stall = inst_req & ~inst_ok;
    assign data_stall = data_req & ~data_ok;

    always_comb begin
        state_d    = state_q;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        excp_done  = 1'b0;
        done       = 1'b0;
        expired    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_elig) begin
                    if (data_excp) begin
                        excp_done = 1'b1;
                    end else begin
                        grant_data = 1'b1;
                        state_d    = S_ADDR;
                    end
                end else if (inst_elig) begin
                    grant_inst = 1'b1;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = S_DATA;
                end else if (wd_hit) begin
                    expired = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    expired = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            bus_req     <= 1'b0;
            bus_wr      <= 1'b0;
            bus_wen     <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            inst_ok     <= 1'b0;
            data_ok     <= 1'b0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            bus_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || (state_q == S_IDLE)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            bus_req <= (state_d == S_ADDR);

            // Bus payload is captured once at grant and held until the next grant.
            if (grant_data) begin
                owner_q   <= 1'b1;
                bus_addr  <= data_addr;
                bus_wr    <= data_wr;
                bus_wen   <= data_wen;
                bus_wdata <= data_wdata;
            end else if (grant_inst) begin
                owner_q   <= 1'b0;
                bus_addr  <= inst_addr;
                bus_wr    <= 1'b0;
                bus_wen   <= 4'b0000;
                bus_wdata <= '0;
            end

            inst_ok     <= finish & ~owner_q;
            data_ok     <= (finish & owner_q) | excp_done;
            bus_timeout <= expired;

            if (finish & ~owner_q) begin
                inst_rdata <= done ? bus_rdata : 32'h0000_0000;
            end
            if (finish & owner_q) begin
                data_rdata <= done ? bus_rdata : 32'h0000_0000;
            end else if (excp_done) begin
                data_rdata <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-schedule model.
module tb_mem_bus_arbiter;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        inst_stall;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_excp;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        data_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_timeout;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_ok(inst_ok), .inst_stall(inst_stall),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_excp(data_excp),
        .data_rdata(data_rdata), .data_ok(data_ok), .data_stall(data_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Model: one in-flight transaction described by its grant cycle and phase lengths.
    int          cyc = 0;
    bit          busy = 0;
    bit          own_d = 0;
    bit          tmo = 0;
    int          g = 0;
    int          txa = 0;
    int          txd = 0;
    int          la = 0;
    int          t_end = 0;
    logic        m_iok = 0, m_dok = 0, m_tmo = 0;
    logic [31:0] m_irdata = 0, m_drdata = 0;
    logic [31:0] m_baddr = 0, m_bwdata = 0;
    logic [3:0]  m_bwen = 0;
    logic        m_bwr = 0;
    bit          wd_known = 1;

    int          force_a = -1, force_d = -1, spur_pct = 0;
    bit          force_rd = 0, auto_req = 0, i_done = 0, d_done = 0;
    logic [31:0] rd_val = 0;

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", n, cyc, a, e);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", n, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        busy = 0; m_iok = 0; m_dok = 0; m_tmo = 0;
        m_irdata = 0; m_drdata = 0; m_baddr = 0; m_bwdata = 0; m_bwen = 0; m_bwr = 0;
        wd_known = 1; i_done = 0; d_done = 0;
    endtask

    // Phase lengths come from the bench's own bus plan; a phase longer than TO times out.
    task automatic start_txn(input bit d, input logic [31:0] a, input logic w,
                             input logic [3:0] we, input logic [31:0] wd);
        busy = 1; own_d = d; g = cyc;
        m_baddr = a; m_bwr = w; m_bwen = we;
        if (d) begin m_bwdata = wd; wd_known = 1; end else wd_known = 0;
        txa = (force_a > 0) ? force_a : 1 + int'($urandom_range(0, 6));
        txd = (force_d > 0) ? force_d : 1 + int'($urandom_range(0, 6));
        la  = (txa <= TO) ? txa : TO;
        if (txa > TO) begin
            t_end = g + TO; tmo = 1;
        end else if (txd > TO) begin
            t_end = g + txa + TO; tmo = 1;
        end else begin
            t_end = g + txa + txd; tmo = 0;
        end
    endtask

    task automatic model_edge();
        bit pi, pd;
        pi = m_iok; pd = m_dok;
        cyc++;
        m_iok = 0; m_dok = 0; m_tmo = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (busy) begin
            if (cyc == t_end) begin
                busy = 0; m_tmo = tmo;
                if (own_d) begin m_dok = 1; m_drdata = tmo ? 32'h0 : bus_rdata; end
                else begin m_iok = 1; m_irdata = tmo ? 32'h0 : bus_rdata; end
            end
        end else if (data_req && !pd) begin
            if (data_excp) begin m_dok = 1; m_drdata = 32'h0; end
            else start_txn(1'b1, data_addr, data_wr, data_wen, data_wdata);
        end else if (inst_req && !pi) begin
            start_txn(1'b0, inst_addr, 1'b0, 4'h0, 32'h0);
        end
    endtask

    task automatic drive_bus();
        bus_addr_ok = busy && (txa <= TO) && (cyc == g + txa - 1);
        bus_data_ok = busy && (txa <= TO) && (cyc == g + txa + txd - 1);
        if (busy && (cyc < g + la) && (cyc != g + txa - 1) &&
            (int'($urandom_range(0, 99)) < spur_pct))
            bus_data_ok = 1'b1;
        bus_rdata = force_rd ? rd_val : $urandom;
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_wen   = data_wr ? 4'($urandom_range(1, 15)) : 4'h0;
        data_excp  = ($urandom_range(0, 7) == 0);
    endtask

    // Requesters hold req through their ok cycle, then issue a new request or go quiet.
    task automatic drive_reqs();
        if (i_done) begin
            i_done = 0;
            inst_req  = 1'($urandom_range(0, 1));
            inst_addr = $urandom & 32'hFFFF_FFFC;
        end else if (!inst_req) begin
            if ($urandom_range(0, 3) == 0) begin
                inst_req = 1'b1; inst_addr = $urandom & 32'hFFFF_FFFC;
            end
        end else if (!m_iok && $urandom_range(0, 63) == 0) begin
            inst_req = 1'b0;
        end
        if (m_iok) i_done = 1;

        if (d_done) begin
            d_done = 0;
            if ($urandom_range(0, 1) == 1) new_data(); else data_req = 1'b0;
        end else if (!data_req) begin
            if ($urandom_range(0, 3) == 0) new_data();
        end else if (!m_dok && $urandom_range(0, 63) == 0) begin
            data_req = 1'b0;
        end
        if (m_dok) d_done = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        drive_bus();
        if (auto_req) drive_reqs();
    endtask

    always @(negedge clk) begin : compare
        logic er;
        er = busy && (cyc >= g) && (cyc < g + la);
        chk1("bus_req", bus_req, er);
        chk32("bus_addr", bus_addr, m_baddr);
        chk1("bus_wr", bus_wr, m_bwr);
        chk32("bus_wen", 32'(bus_wen), 32'(m_bwen));
        if (wd_known) chk32("bus_wdata", bus_wdata, m_bwdata);
        chk1("inst_ok", inst_ok, m_iok);
        chk1("data_ok", data_ok, m_dok);
        chk32("inst_rdata", inst_rdata, m_irdata);
        chk32("data_rdata", data_rdata, m_drdata);
        chk1("bus_timeout", bus_timeout, m_tmo);
        chk1("inst_stall", inst_stall, inst_req & ~m_iok);
        chk1("data_stall", data_stall, data_req & ~m_dok);
    end

    initial begin
        rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wen = 0;
        data_addr = 0; data_wdata = 0; data_excp = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        model_reset();
        #2;
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_inst_ok", inst_ok, 1'b0);
        chk1("rst_data_ok", data_ok, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'h0);
        chk32("rst_inst_rdata", inst_rdata, 32'h0);
        step(); step();
        rst = 0;
        step(); step();

        // IF only, fastest bus
        force_a = 1; force_d = 1; force_rd = 1; rd_val = 32'h2408_0001;
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        #3 chk1("if_stall_c0", inst_stall, 1'b1);
        step(); #3;
        chk1("if_bus_req", bus_req, 1'b1);
        chk32("if_bus_addr", bus_addr, 32'hBFC0_0000);
        chk1("if_bus_wr", bus_wr, 1'b0);
        chk1("if_stall_c1", inst_stall, 1'b1);
        step(); #3;
        chk1("if_bus_req_c2", bus_req, 1'b0);
        chk1("if_stall_c2", inst_stall, 1'b1);
        step(); #3;
        chk1("if_ok", inst_ok, 1'b1);
        chk32("if_rdata", inst_rdata, 32'h2408_0001);
        chk1("if_stall_ok", inst_stall, 1'b0);
        step(); inst_req = 0; #3;
        chk1("if_ok_gone", inst_ok, 1'b0);
        chk32("if_rdata_hold", inst_rdata, 32'h2408_0001);

        // simultaneous requests: MEM first, IF right after data_ok
        step(); force_rd = 0;
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_wen = 4'hF; data_addr = 32'h8000_0010;
        data_wdata = 32'hDEAD_BEEF; data_excp = 0;
        step(); #3;
        chk1("sim_bus_req", bus_req, 1'b1);
        chk1("sim_bus_wr", bus_wr, 1'b1);
        chk32("sim_bus_wen", 32'(bus_wen), 32'hF);
        chk32("sim_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk32("sim_bus_addr", bus_addr, 32'h8000_0010);
        step(); step(); #3;
        chk1("sim_data_ok", data_ok, 1'b1);
        chk1("sim_inst_ok_low", inst_ok, 1'b0);
        step(); data_req = 0; data_wr = 0; data_wen = 0; #3;
        chk1("sim_if_grant", bus_req, 1'b1);
        chk32("sim_if_addr", bus_addr, 32'hBFC0_0004);
        chk1("sim_if_wr", bus_wr, 1'b0);
        chk32("sim_if_wen", 32'(bus_wen), 32'h0);
        step(); step(); #3;
        chk1("sim_inst_ok", inst_ok, 1'b1);
        step(); inst_req = 0;

        // address exception: no bus activity, immediate data_ok
        step(); data_req = 1; data_excp = 1; data_addr = 32'h8000_0001; data_wr = 0;
        step(); #3;
        chk1("exc_data_ok", data_ok, 1'b1);
        chk32("exc_rdata", data_rdata, 32'h0);
        chk1("exc_bus_req", bus_req, 1'b0);
        step(); data_req = 0; data_excp = 0; #3;
        chk1("exc_ok_gone", data_ok, 1'b0);
        chk1("exc_bus_req2", bus_req, 1'b0);
        chk32("exc_addr_held", bus_addr, 32'hBFC0_0004);

        // wait states with spurious data_ok during ADDR
        force_a = 5; force_d = 4; spur_pct = 100;
        step(); data_req = 1; data_wr = 1; data_wen = 4'b0011;
        data_addr = 32'h8000_0020; data_wdata = 32'h1234_1234;
        for (int k = 1; k <= 5; k++) begin
            step(); #3;
            chk1("ws_bus_req", bus_req, 1'b1);
            chk32("ws_addr", bus_addr, 32'h8000_0020);
            chk32("ws_wen", 32'(bus_wen), 32'h3);
            chk32("ws_wdata", bus_wdata, 32'h1234_1234);
        end
        for (int k = 6; k <= 9; k++) begin
            step(); #3;
            chk1("ws_data_phase_req", bus_req, 1'b0);
            chk1("ws_no_early_ok", data_ok, 1'b0);
        end
        step(); #3;
        chk1("ws_data_ok", data_ok, 1'b1);
        chk1("ws_no_timeout", bus_timeout, 1'b0);
        step(); data_req = 0; data_wr = 0; data_wen = 0; #3;
        chk1("ws_single_ok", data_ok, 1'b0);
        spur_pct = 0;

        // watchdog: addr_ok never comes
        force_a = 99; force_d = 1;
        step(); inst_req = 1; inst_addr = 32'hBFC0_0008;
        for (int k = 1; k <= 5; k++) begin
            step(); #3;
            chk1("wd_bus_req", bus_req, 1'b1);
            chk1("wd_no_ok", inst_ok, 1'b0);
            chk1("wd_no_pulse", bus_timeout, 1'b0);
        end
        step(); #3;
        chk1("wd_inst_ok", inst_ok, 1'b1);
        chk1("wd_timeout", bus_timeout, 1'b1);
        chk32("wd_rdata", inst_rdata, 32'h0);
        chk1("wd_bus_req_off", bus_req, 1'b0);
        force_a = 1; force_d = 1;
        step(); inst_req = 0; data_req = 1; data_wr = 0; data_wen = 0; data_addr = 32'h8000_0040; #3;
        chk1("wd_pulse_gone", bus_timeout, 1'b0);
        step(); #3;
        chk1("wd_next_req", bus_req, 1'b1);
        chk32("wd_next_addr", bus_addr, 32'h8000_0040);
        step(); step(); #3;
        chk1("wd_next_ok", data_ok, 1'b1);
        step(); data_req = 0;

        // asynchronous reset during DATA
        force_a = 1; force_d = 3;
        step(); inst_req = 1; inst_addr = 32'hBFC0_0100;
        step();
        step();
        #1 rst = 1; model_reset();
        #1;
        chk1("ar_bus_req", bus_req, 1'b0);
        chk32("ar_bus_addr", bus_addr, 32'h0);
        chk32("ar_bus_wen", 32'(bus_wen), 32'h0);
        chk1("ar_bus_wr", bus_wr, 1'b0);
        chk32("ar_bus_wdata", bus_wdata, 32'h0);
        chk32("ar_inst_rdata", inst_rdata, 32'h0);
        chk32("ar_data_rdata", data_rdata, 32'h0);
        chk1("ar_inst_ok", inst_ok, 1'b0);
        chk1("ar_data_ok", data_ok, 1'b0);
        chk1("ar_timeout", bus_timeout, 1'b0);
        inst_req = 0;
        step(); step();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            step(); #3 chk1("ar_no_stale_ok", inst_ok, 1'b0);
        end
        force_d = 1;
        inst_req = 1; inst_addr = 32'hBFC0_0200;
        step(); #3;
        chk1("ar_new_req", bus_req, 1'b1);
        chk32("ar_new_addr", bus_addr, 32'hBFC0_0200);
        step(); step(); #3;
        chk1("ar_new_ok", inst_ok, 1'b1);
        step(); inst_req = 0;

        // randomized traffic
        force_a = -1; force_d = -1; force_rd = 0; spur_pct = 25; auto_req = 1;
        step();
        i_done = 0; d_done = 0;
        repeat (3000) step();
        auto_req = 0; inst_req = 0; data_req = 0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
